wb_rr_arbiter: RTL and testbench

Round-robin Wishbone B4 arbiter that shares one slave port among NUM_MASTERS masters, e.g. the SDRAM controller's reserved port or sram0 between the picorv32 data master and a DMA engine. It holds ownership for a whole bus cycle, including registered bursts, until the owning master drops cyc. A watchdog terminates a stalled slave access with an error.

---
 rtl/wb_rr_arbiter_pkg.sv | 23 ++
 rtl/wb_rr_pick.sv | 31 +++
 rtl/wb_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared Wishbone arbiter definitions: cycle/burst type encodings and the
// arbiter state encoding reused by sibling bus arbiters.
package wb_rr_arbiter_pkg;

    // Wishbone B4 cycle type identifiers (cti)
    localparam logic [2:0] CTI_CLASSIC      = 3'b000;
    localparam logic [2:0] CTI_CONST_BURST  = 3'b001;
    localparam logic [2:0] CTI_INC_BURST    = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

    // Wishbone B4 burst type extensions (bte)
    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // Arbiter ownership state
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority encoder: picks the first requester at or after ptr,
// searching upward and wrapping modulo NUM_MASTERS.
module wb_rr_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]       gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the candidates in priority order starting at ptr; first hit wins
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int off = 0; off < NUM_MASTERS; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NUM_MASTERS);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = found ? (NUM_MASTERS'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: one slave port shared by NUM_MASTERS
// masters. Ownership lasts for a whole bus cycle (until the owner drops cyc),
// and a watchdog forces err on a slave access stalled for TIMEOUT cycles.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*32-1:0] m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
    output logic [31:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    input  logic [31:0]               s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   busy;
    logic                   stb_g;
    logic                   wd_err;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req     (m_cyc_i),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    assign busy    = (state_q == ARB_BUSY);
    // Owner's strobe; only registered state and master inputs feed it, so
    // slave ack/err never loop back into s_cyc_o/s_stb_o.
    assign stb_g   = busy & m_stb_i[gidx_q] & m_cyc_i[gidx_q];
    assign grant_o = grant_q;
    assign m_dat_o = s_dat_i;

    // Ownership FSM next-state: grant from IDLE, release when owner drops cyc
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        if (state_q == ARB_IDLE) begin
            if (|m_cyc_i) begin
                state_d = ARB_BUSY;
                grant_d = pick_gnt;
                gidx_d  = pick_idx;
            end
        end else begin
            if (!m_cyc_i[gidx_q]) begin
                state_d = ARB_IDLE;
                grant_d = '0;
                ptr_d   = (gidx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;
            end
        end
    end

    // Ownership FSM registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

    // Slave-side mux of the owner's request and routing of its termination
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (busy) begin
            s_adr_o         = m_adr_i[gidx_q*AW +: AW];
            s_dat_o         = m_dat_i[gidx_q*32 +: 32];
            s_sel_o         = m_sel_i[gidx_q*4 +: 4];
            s_we_o          = m_we_i[gidx_q];
            s_cyc_o         = m_cyc_i[gidx_q];
            s_stb_o         = stb_g;
            s_cti_o         = m_cti_i[gidx_q*3 +: 3];
            s_bte_o         = m_bte_i[gidx_q*2 +: 2];
            m_ack_o[gidx_q] = s_ack_i & stb_g;
            m_err_o[gidx_q] = (s_err_i & stb_g) | wd_err;
        end
    end

    if (TIMEOUT > 0) begin : g_wd
        localparam int WD_W = $clog2(TIMEOUT + 1);

        logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
        logic            stall;

        // Count stalled strobe cycles; a stall excludes ack, so a late ack in
        // the firing cycle always wins over the forced err.
        always_comb begin
            stall    = stb_g & ~s_ack_i & ~s_err_i;
            wd_err   = stall && (wd_cnt_q == WD_W'(TIMEOUT - 1));
            wd_cnt_d = (stall && !wd_err) ? wd_cnt_q + 1'b1 : '0;
        end

        // Watchdog counter register
        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_d;
            end
        end
    end else begin : g_no_wd
        assign wd_err = 1'b0;
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter (2 masters): directed scenarios push
// expected terminations and grant transitions into queues; negedge monitors
// pop and compare whenever the DUT presents them.
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] m_adr = '0;
    logic [63:0] m_dat = '0;
    logic [7:0]  m_sel = '0;
    logic [1:0]  m_we = '0, m_cyc = '0, m_stb = '0;
    logic [5:0]  m_cti = '0;
    logic [3:0]  m_bte = '0;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0, s_err_i = 1'b0;

    logic [31:0] m_dat_o, s_adr_o, s_dat_o;
    logic [1:0]  m_ack_o, m_err_o, grant_o, s_bte_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]  s_cti_o;

    logic [31:0] nw_m_dat_o, nw_s_adr_o, nw_s_dat_o;
    logic [1:0]  nw_m_ack_o, nw_m_err_o, nw_grant_o, nw_s_bte_o;
    logic [3:0]  nw_s_sel_o;
    logic        nw_s_we_o, nw_s_cyc_o, nw_s_stb_o;
    logic [2:0]  nw_s_cti_o;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.NUM_MASTERS(2), .AW(32), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
    );

    wb_rr_arbiter #(.NUM_MASTERS(2), .AW(32), .TIMEOUT(0)) dut_nowd (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(nw_m_dat_o), .m_ack_o(nw_m_ack_o), .m_err_o(nw_m_err_o),
        .s_adr_o(nw_s_adr_o), .s_dat_o(nw_s_dat_o), .s_sel_o(nw_s_sel_o), .s_we_o(nw_s_we_o),
        .s_cyc_o(nw_s_cyc_o), .s_stb_o(nw_s_stb_o), .s_cti_o(nw_s_cti_o), .s_bte_o(nw_s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(nw_grant_o)
    );

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t       eq[$];
    logic [1:0] gq[$];
    logic [1:0] gprev = 2'b00;
    int         n_vec = 0;
    int         n_miss = 0;
    bit         nowd_err_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Termination monitor: every ack/err the DUT presents must match the queue head
    always @(negedge clk) begin
        rsp_t r;
        if ((m_ack_o | m_err_o) != 2'b00) begin
            n_vec++;
            if (eq.size() == 0) begin
                n_miss++;
                $display("FAIL rsp_unexpected: got ack=%b err=%b expected no termination", m_ack_o, m_err_o);
            end else begin
                r = eq.pop_front();
                if (m_ack_o !== r.ack || m_err_o !== r.err || m_dat_o !== r.dat) begin
                    n_miss++;
                    $display("FAIL rsp: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                             m_ack_o, m_err_o, m_dat_o, r.ack, r.err, r.dat);
                end
            end
        end
        if (nw_m_err_o != 2'b00) nowd_err_seen = 1'b1;
    end

    // Grant monitor: every change of grant_o must match the next expected value
    always @(negedge clk) begin
        logic [1:0] g;
        if (grant_o !== gprev) begin
            n_vec++;
            if (gq.size() == 0) begin
                n_miss++;
                $display("FAIL grant_unexpected: got %b expected no change from %b", grant_o, gprev);
            end else begin
                g = gq.pop_front();
                if (grant_o !== g) begin
                    n_miss++;
                    $display("FAIL grant_seq: got %b expected %b", grant_o, g);
                end
            end
            gprev = grant_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int idx, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic [2:0] cti);
        m_cyc[idx]          = cyc;
        m_stb[idx]          = stb;
        m_adr[idx*32 +: 32] = adr;
        m_dat[idx*32 +: 32] = ~adr;
        m_sel[idx*4 +: 4]   = 4'hF;
        m_we[idx]           = 1'b0;
        m_cti[idx*3 +: 3]   = cti;
        m_bte[idx*2 +: 2]   = BTE_LINEAR;
    endtask

    task automatic wait_grant(input int idx);
        logic [1:0] want;
        want = 2'(1 << idx);
        for (int k = 0; k < 20 && grant_o !== want; k++) tick();
        chk("grant_wait", 32'(grant_o), 32'(want));
    endtask

    // One single-beat access by master idx, acked on its first BUSY cycle
    task automatic serve(input int idx, input logic [31:0] d, input bit rearm);
        rsp_t       r;
        logic [1:0] want;
        want = 2'(1 << idx);
        gq.push_back(want);
        wait_grant(idx);
        s_dat_i = d;
        s_ack_i = 1'b1;
        r.ack = want; r.err = 2'b00; r.dat = d;
        eq.push_back(r);
        tick();
        s_ack_i    = 1'b0;
        m_cyc[idx] = 1'b0;
        m_stb[idx] = 1'b0;
        gq.push_back(2'b00);
        tick();
        chk("release", 32'(grant_o), 32'd0);
        if (rearm) begin
            m_cyc[idx] = 1'b1;
            m_stb[idx] = 1'b1;
        end
    endtask

    initial begin
        rsp_t r;
        s_dat_i = 32'h5A5A_5A5A;
        tick();
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_stb", 32'(s_stb_o), 32'd0);
        chk("rst_ack", 32'(m_ack_o), 32'd0);
        chk("rst_err", 32'(m_err_o), 32'd0);
        chk("rst_dat", m_dat_o, 32'h5A5A_5A5A);
        rst_n = 1'b1;
        tick();

        // single master classic read, slave acks in BUSY cycle 3
        gq.push_back(2'b01);
        set_m(0, 1'b1, 1'b1, 32'h100, CTI_CLASSIC);
        chk("t1_idle_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        chk("t1_grant", 32'(grant_o), 32'h1);
        chk("t1_cyc", 32'(s_cyc_o), 32'd1);
        chk("t1_stb", 32'(s_stb_o), 32'd1);
        chk("t1_adr", s_adr_o, 32'h100);
        chk("t1_cti", 32'(s_cti_o), 32'(CTI_CLASSIC));
        tick();
        tick();
        s_dat_i = 32'hDEAD_BEEF;
        s_ack_i = 1'b1;
        r.ack = 2'b01; r.err = 2'b00; r.dat = 32'hDEAD_BEEF;
        eq.push_back(r);
        tick();
        s_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        gq.push_back(2'b00);
        tick();
        chk("t1_release", 32'(grant_o), 32'd0);

        // simultaneous requests from reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        gq.push_back(2'b01);
        set_m(0, 1'b1, 1'b1, 32'h200, CTI_CLASSIC);
        set_m(1, 1'b1, 1'b1, 32'h300, CTI_CLASSIC);
        tick();
        chk("t2_first", 32'(grant_o), 32'h1);
        chk("t2_adr0", s_adr_o, 32'h200);
        s_dat_i = 32'h1111_0000;
        s_ack_i = 1'b1;
        r.ack = 2'b01; r.err = 2'b00; r.dat = 32'h1111_0000;
        eq.push_back(r);
        tick();
        s_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        gq.push_back(2'b00);
        gq.push_back(2'b10);
        tick();
        chk("t2_gap", 32'(grant_o), 32'd0);
        tick();
        chk("t2_second", 32'(grant_o), 32'h2);
        chk("t2_adr1", s_adr_o, 32'h300);
        s_dat_i = 32'h2222_0000;
        s_ack_i = 1'b1;
        r.ack = 2'b10; r.err = 2'b00; r.dat = 32'h2222_0000;
        eq.push_back(r);
        tick();
        s_ack_i = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        gq.push_back(2'b00);
        tick();
        set_m(0, 1'b1, 1'b1, 32'h400, CTI_CLASSIC);
        set_m(1, 1'b1, 1'b1, 32'h500, CTI_CLASSIC);

        // next simultaneous request goes to m0, then strict alternation
        serve(0, 32'h3333_0000, 1'b1);
        serve(1, 32'h4444_0000, 1'b1);
        serve(0, 32'h5555_0000, 1'b1);
        serve(1, 32'h6666_0000, 1'b0);
        serve(0, 32'h7777_0000, 1'b0);

        // m1 4-beat incrementing burst while m0 waits
        gq.push_back(2'b10);
        set_m(1, 1'b1, 1'b1, 32'h1000, CTI_INC_BURST);
        set_m(0, 1'b1, 1'b1, 32'h2000, CTI_CLASSIC);
        tick();
        chk("t4_grant", 32'(grant_o), 32'h2);
        for (int b = 0; b < 4; b++) begin
            m_cti[5:3]  = (b < 3) ? CTI_INC_BURST : CTI_END_OF_BURST;
            m_adr[63:32] = 32'h1000 + 32'(4 * b);
            s_dat_i = 32'hB000_0000 + 32'(b);
            s_ack_i = 1'b1;
            r.ack = 2'b10; r.err = 2'b00; r.dat = 32'hB000_0000 + 32'(b);
            eq.push_back(r);
            #1;
            chk("t4_cti", 32'(s_cti_o), 32'((b < 3) ? CTI_INC_BURST : CTI_END_OF_BURST));
            chk("t4_adr", s_adr_o, 32'h1000 + 32'(4 * b));
            tick();
            chk("t4_hold", 32'(grant_o), 32'h2);
        end
        s_ack_i = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        gq.push_back(2'b00);
        tick();
        chk("t4_release", 32'(grant_o), 32'd0);
        serve(0, 32'h8888_0000, 1'b0);

        // watchdog: slave never answers, err in BUSY cycles 15 and 31
        s_dat_i = 32'h0BAD_0BAD;
        r.ack = 2'b00; r.err = 2'b01; r.dat = 32'h0BAD_0BAD;
        eq.push_back(r);
        eq.push_back(r);
        gq.push_back(2'b01);
        set_m(0, 1'b1, 1'b1, 32'h3000, CTI_CLASSIC);
        tick();
        for (int c = 0; c < 34; c++) begin
            chk("t5_wd_err", 32'(m_err_o), (c == 15 || c == 31) ? 32'h1 : 32'h0);
            if (c == 15 || c == 31) chk("t5_nowd_err", 32'(nw_m_err_o), 32'd0);
            if (c == 20) chk("t5_nowd_busy", 32'(nw_grant_o), 32'h1);
            tick();
        end

        // asynchronous reset in the middle of the stall
        #2;
        gq.push_back(2'b00);
        rst_n = 1'b0;
        #1;
        chk("t6_cyc", 32'(s_cyc_o), 32'd0);
        chk("t6_stb", 32'(s_stb_o), 32'd0);
        chk("t6_grant", 32'(grant_o), 32'd0);
        set_m(1, 1'b1, 1'b1, 32'h600, CTI_CLASSIC);
        tick();
        tick();
        rst_n = 1'b1;
        serve(0, 32'h9999_0000, 1'b0);
        serve(1, 32'hAAAA_0000, 1'b0);

        tick();
        tick();
        tick();
        chk("rsp_queue_empty", 32'(eq.size()), 32'd0);
        chk("grant_queue_empty", 32'(gq.size()), 32'd0);
        chk("nowd_never_err", 32'(nowd_err_seen), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
